// File: rtl/multicycle_control_unit_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, opcodes, ALU ops,
// immediate formats and result-mux selects.
package multicycle_control_unit_pkg;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      TRAP      = 3'd5
   } cu_state;

   typedef enum logic [6:0] {
      r_type = 7'b0110011,
      i_alu  = 7'b0010011,
      load   = 7'b0000011,
      store  = 7'b0100011,
      branch = 7'b1100011,
      jal    = 7'b1101111,
      lui    = 7'b0110111
   } opcode;

   typedef enum logic [2:0] {
      Sum = 3'd0,
      Sub = 3'd1,
      And = 3'd2,
      Or  = 3'd3,
      Xor = 3'd4,
      Slt = 3'd5,
      Sll = 3'd6,
      Srl = 3'd7
   } alu_ctrl;

   typedef enum logic [2:0] {
      Imm    = 3'd0,
      Store  = 3'd1,
      Branch = 3'd2,
      Jump   = 3'd3,
      Upper  = 3'd4
   } instr_format;

   typedef enum logic [1:0] {
      Alu     = 2'd0,
      MemData = 2'd1,
      PcPlus4 = 2'd2
   } result_src;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational funct3/funct7[5] -> ALU operation map. Subtract is only
// honoured for R-type; I-ALU with imm[10] set still adds.
module multicycle_control_unit_alu_decoder
   import multicycle_control_unit_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       allow_sub,
   output alu_ctrl    alu_op
);

   always_comb begin
      alu_op = Sum;
      case (funct3)
         3'b000:  alu_op = (allow_sub && funct7b5) ? Sub : Sum;
         3'b001:  alu_op = Sll;
         3'b010:  alu_op = Slt;
         3'b011:  alu_op = Slt;
         3'b100:  alu_op = Xor;
         3'b101:  alu_op = Srl;
         3'b110:  alu_op = Or;
         3'b111:  alu_op = And;
         default: alu_op = Sum;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Define CU_TRAP_EN to add the TRAP state for illegal opcodes and memory timeouts.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ALU_WIDTH  = 3,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  EQ,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  MemWrite,
   output logic                  IRWrite,
   output logic                  PCWrite,
   output logic                  PCsrc,
   output logic                  RegWrite,
   output logic                  ALUsrc,
   output logic [ALU_WIDTH-1:0]  ALUctrl,
   output instr_format           ImmSrc,
   output result_src             ResultSrc,
   output logic                  trap
);

   cu_state state, state_nxt;
   opcode   op;
   logic    op_legal;
   logic    br_taken;
   logic    wait_expired;
   alu_ctrl alu_dec;
   alu_ctrl alu_op;

   assign op = opcode'(instr[6:0]);

   wire unused_instr = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

   always_comb begin
      op_legal = 1'b0;
      case (op)
         r_type, i_alu, load, store, branch, jal, lui: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   // beq / bne only; other funct3 values fall through as not-taken
   assign br_taken = ((instr[14:12] == 3'b000) &&  EQ) ||
                     ((instr[14:12] == 3'b001) && !EQ);

   multicycle_control_unit_alu_decoder u_alu_dec (
      .funct3    (instr[14:12]),
      .funct7b5  (instr[30]),
      .allow_sub (op == r_type),
      .alu_op    (alu_dec)
   );

`ifdef CU_TRAP_EN
   localparam int      WAIT_W      = $clog2(MAX_WAIT + 2);
   localparam cu_state ILLEGAL_NXT = TRAP;

   logic [WAIT_W-1:0] wait_cnt;

   // counts consecutive stalled cycles of the current memory request
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if ((state == FETCH || state == MEMORY) && !mem_ready)
         wait_cnt <= wait_cnt + 1'b1;
      else
         wait_cnt <= '0;
   end

   assign wait_expired = (wait_cnt >= WAIT_W'(MAX_WAIT)) && !mem_ready;
   assign trap         = (state == TRAP) && !rst;
`else
   localparam cu_state ILLEGAL_NXT     = FETCH;
   localparam int      unused_max_wait = MAX_WAIT;

   assign wait_expired = 1'b0;
   assign trap         = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= FETCH;
      else
         state <= state_nxt;
   end

   // Outputs are forced to their idle values while rst is high, even mid-request.
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCsrc     = 1'b0;
      RegWrite  = 1'b0;
      ALUsrc    = 1'b0;
      alu_op    = Sum;
      ImmSrc    = Imm;
      ResultSrc = Alu;
      if (!rst) begin
         case (state)
            FETCH: begin
               mem_req = 1'b1;
               if (wait_expired)
                  state_nxt = TRAP;
               else if (mem_ready) begin
                  IRWrite   = 1'b1;
                  PCWrite   = 1'b1;
                  state_nxt = DECODE;
               end
            end
            DECODE:
               state_nxt = op_legal ? EXECUTE : ILLEGAL_NXT;
            EXECUTE: begin
               state_nxt = FETCH;
               case (op)
                  r_type: begin
                     alu_op    = alu_dec;
                     state_nxt = WRITEBACK;
                  end
                  i_alu: begin
                     ALUsrc    = 1'b1;
                     alu_op    = alu_dec;
                     state_nxt = WRITEBACK;
                  end
                  load: begin
                     ALUsrc    = 1'b1;
                     state_nxt = MEMORY;
                  end
                  store: begin
                     ALUsrc    = 1'b1;
                     ImmSrc    = Store;
                     state_nxt = MEMORY;
                  end
                  branch: begin
                     alu_op  = Sub;
                     ImmSrc  = Branch;
                     PCWrite = br_taken;
                     PCsrc   = br_taken;
                  end
                  jal: begin
                     ImmSrc    = Jump;
                     PCWrite   = 1'b1;
                     PCsrc     = 1'b1;
                     state_nxt = WRITEBACK;
                  end
                  lui: begin
                     ImmSrc    = Upper;
                     state_nxt = WRITEBACK;
                  end
                  default: state_nxt = FETCH;
               endcase
            end
            MEMORY: begin
               mem_req  = 1'b1;
               MemWrite = (op == store);
               if (wait_expired)
                  state_nxt = TRAP;
               else if (mem_ready)
                  state_nxt = (op == store) ? FETCH : WRITEBACK;
            end
            WRITEBACK: begin
               RegWrite  = 1'b1;
               ResultSrc = (op == load) ? MemData : (op == jal) ? PcPlus4 : Alu;
               state_nxt = FETCH;
            end
            TRAP:
               state_nxt = TRAP;
            default:
               state_nxt = FETCH;
         endcase
      end
   end

   assign ALUctrl = alu_op;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; honours CU_TRAP_EN when defined.
module tb_multicycle_control_unit;
   import multicycle_control_unit_pkg::*;

   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;

   localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
   localparam logic [31:0] I_ADDIH = 32'h40008093; // addi with imm[10] set
   localparam logic [31:0] I_SRLI  = 32'h0010D093; // srli x1,x1,1
   localparam logic [31:0] I_SUB   = 32'h402081B3; // sub x3,x1,x2
   localparam logic [31:0] I_AND   = 32'h0020F1B3; // and x3,x1,x2
   localparam logic [31:0] I_BNE   = 32'h00209463; // bne x1,x2,8
   localparam logic [31:0] I_BEQ   = 32'h00208463; // beq x1,x2,8
   localparam logic [31:0] I_LW    = 32'h00012083; // lw x1,0(x2)
   localparam logic [31:0] I_SW    = 32'h00112023; // sw x1,0(x2)
   localparam logic [31:0] I_JAL   = 32'h008000EF; // jal x1,8
   localparam logic [31:0] I_LUI   = 32'h000010B7; // lui x1,1
   localparam logic [31:0] I_ILL   = 32'h0000007F;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        EQ;
   logic        mem_ready;
   logic        mem_req, MemWrite, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc, trap;
   logic [2:0]  ALUctrl;
   instr_format ImmSrc;
   result_src   ResultSrc;
   logic [15:0] outv;
   int          errors = 0;
   int          checks = 0;

   multicycle_control_unit #(.DATA_WIDTH(32), .ALU_WIDTH(3), .MAX_WAIT(15)) dut (
      .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
      .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .trap(trap)
   );

   always #5 clk = ~clk;

   assign outv = {trap, mem_req, MemWrite, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc,
                  ALUctrl, 3'(ImmSrc), 2'(ResultSrc)};

   // field order: mem_req MemWrite IRWrite PCWrite PCsrc RegWrite ALUsrc ALUctrl ImmSrc ResultSrc trap
   function automatic logic [15:0] o(input logic mr, mw, irw, pcw, pcs, rw, as,
                                     input alu_ctrl ac, input instr_format im,
                                     input result_src rs, input logic tr);
      return {tr, mr, mw, irw, pcw, pcs, rw, as, 3'(ac), 3'(im), 2'(rs)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_o(input string tag, input logic [15:0] e);
      #1;
      checks++;
      assert (outv === e) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, outv, e);
      end
   endtask

   logic [15:0] z, fgo, fwait;

   initial begin
      z     = o(N,N,N,N,N,N,N, Sum, Imm, Alu, N);
      fgo   = o(Y,N,Y,Y,N,N,N, Sum, Imm, Alu, N);
      fwait = o(Y,N,N,N,N,N,N, Sum, Imm, Alu, N);

      rst = 1'b1; instr = I_ADDI; EQ = 1'b0; mem_ready = 1'b1;
      tick(); tick();
      expect_o("reset_idle", z);

      // addi: 4-cycle path with mem_ready held high
      rst = 1'b0;
      expect_o("addi_c1_fetch", fgo);
      tick(); expect_o("addi_c2_decode", z);
      tick(); expect_o("addi_c3_exec", o(N,N,N,N,N,N,Y, Sum, Imm, Alu, N));
      tick(); expect_o("addi_c4_wb", o(N,N,N,N,N,Y,N, Sum, Imm, Alu, N));
      tick(); expect_o("addi_c5_fetch", fgo);

      // bne not equal -> taken
      instr = I_BNE; EQ = 1'b0;
      tick(); expect_o("bne_ne_decode", z);
      tick(); expect_o("bne_ne_exec", o(N,N,N,Y,Y,N,N, Sub, Branch, Alu, N));
      tick(); expect_o("bne_ne_fetch", fgo);
      // bne equal -> not taken
      EQ = 1'b1;
      tick(); expect_o("bne_eq_decode", z);
      tick(); expect_o("bne_eq_exec", o(N,N,N,N,N,N,N, Sub, Branch, Alu, N));
      tick(); expect_o("bne_eq_fetch", fgo);
      // beq equal -> taken
      instr = I_BEQ;
      tick(); tick(); expect_o("beq_eq_exec", o(N,N,N,Y,Y,N,N, Sub, Branch, Alu, N));
      tick(); expect_o("beq_eq_fetch", fgo);

      // R-type sub / and
      instr = I_SUB; EQ = 1'b0;
      tick(); tick(); expect_o("sub_exec", o(N,N,N,N,N,N,N, Sub, Imm, Alu, N));
      tick(); expect_o("sub_wb", o(N,N,N,N,N,Y,N, Sum, Imm, Alu, N));
      tick(); instr = I_AND;
      tick(); tick(); expect_o("and_exec", o(N,N,N,N,N,N,N, And, Imm, Alu, N));
      tick(); tick();

      // I-ALU: funct7[5]-like bit must not turn add into sub; srli maps to Srl
      instr = I_ADDIH;
      tick(); tick(); expect_o("addih_exec", o(N,N,N,N,N,N,Y, Sum, Imm, Alu, N));
      tick(); tick(); instr = I_SRLI;
      tick(); tick(); expect_o("srli_exec", o(N,N,N,N,N,N,Y, Srl, Imm, Alu, N));
      tick(); tick();

      // lw with three stalled MEMORY cycles
      instr = I_LW;
      expect_o("lw_fetch", fgo);
      tick(); expect_o("lw_decode", z);
      tick(); expect_o("lw_exec", o(N,N,N,N,N,N,Y, Sum, Imm, Alu, N));
      mem_ready = 1'b0;
      tick(); expect_o("lw_mem_w1", fwait);
      tick(); expect_o("lw_mem_w2", fwait);
      tick(); expect_o("lw_mem_w3", fwait);
      mem_ready = 1'b1;
      expect_o("lw_mem_ready", fwait);
      tick(); expect_o("lw_wb", o(N,N,N,N,N,Y,N, Sum, Imm, MemData, N));
      tick(); expect_o("lw_fetch_after", fgo);

      // sw: MemWrite only in MEMORY, no RegWrite
      instr = I_SW;
      tick(); expect_o("sw_decode", z);
      tick(); expect_o("sw_exec", o(N,N,N,N,N,N,Y, Sum, Store, Alu, N));
      tick(); expect_o("sw_mem", o(Y,Y,N,N,N,N,N, Sum, Imm, Alu, N));
      tick(); expect_o("sw_fetch", fgo);

      // jal and lui
      instr = I_JAL;
      tick(); tick(); expect_o("jal_exec", o(N,N,N,Y,Y,N,N, Sum, Jump, Alu, N));
      tick(); expect_o("jal_wb", o(N,N,N,N,N,Y,N, Sum, Imm, PcPlus4, N));
      tick(); instr = I_LUI;
      tick(); tick(); expect_o("lui_exec", o(N,N,N,N,N,N,N, Sum, Upper, Alu, N));
      tick(); expect_o("lui_wb", o(N,N,N,N,N,Y,N, Sum, Imm, Alu, N));

      // FETCH stall holds state
      tick(); mem_ready = 1'b0;
      expect_o("fetch_stall1", fwait);
      tick(); expect_o("fetch_stall2", fwait);
      mem_ready = 1'b1;
      expect_o("fetch_release", fgo);

      // async reset in the middle of a MEMORY stall
      instr = I_LW;
      tick(); tick(); mem_ready = 1'b0;
      tick(); expect_o("rstmem_mem", fwait);
      rst = 1'b1;
      expect_o("rstmem_async_idle", z);
      rst = 1'b0;
      expect_o("rstmem_fetch", fwait);
      tick(); expect_o("rstmem_fetch_hold", fwait);

      // illegal opcode
      mem_ready = 1'b1; instr = I_ILL;
      expect_o("ill_fetch", fgo);
      tick(); expect_o("ill_decode", z);
      tick();
`ifdef CU_TRAP_EN
      expect_o("ill_trap", o(N,N,N,N,N,N,N, Sum, Imm, Alu, Y));
      tick(); tick(); expect_o("ill_trap_sticky", o(N,N,N,N,N,N,N, Sum, Imm, Alu, Y));
      rst = 1'b1;
      expect_o("ill_trap_rst", z);
      rst = 1'b0;
      expect_o("ill_trap_exit", fgo);
`else
      expect_o("ill_nop_fetch", fgo);
      tick(); expect_o("ill_nop_decode_again", z);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
